// File: rtl/imm_pkg.sv
// Shared types and opcode constants for the immediate-generation stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package imm_pkg;

  // Immediate format codes; the encoding is visible on out_fmt.
  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_NONE = 3'd7
  } fmt_e;

  // RV32 major opcodes (inst[6:0]) recognised by the decoder.
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [15:0] ILLEGAL_CNT_MAX = 16'hFFFF;

  // Map a major opcode to its immediate format; unknown opcodes give NONE.
  function automatic fmt_e opcode_fmt(input logic [6:0] opc);
    fmt_e f;
    case (opc)
      OPC_LUI, OPC_AUIPC:                         f = FMT_U;
      OPC_JAL:                                    f = FMT_J;
      OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_SYSTEM: f = FMT_I;
      OPC_STORE:                                  f = FMT_S;
      OPC_BRANCH:                                 f = FMT_B;
      OPC_OP:                                     f = FMT_R;
      default:                                    f = FMT_NONE;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/imm_extract.sv
// Combinational RV32 immediate extractor: opcode -> format, sign-extended immediate, illegal flag.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inst_i.
// Ports: inst_i (raw instruction) -> imm_o (XLEN immediate), fmt_o (format code), illegal_o.
module imm_extract
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst_i,
  output logic [XLEN-1:0] imm_o,
  output fmt_e            fmt_o,
  output logic            illegal_o
);

  logic [31:0] imm32;

  always_comb begin
    fmt_o     = opcode_fmt(inst_i[6:0]);
    illegal_o = (fmt_o == FMT_NONE);
    imm32     = '0;
    case (fmt_o)
      FMT_I: imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
      FMT_S: imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      FMT_B: imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
      FMT_J: imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
      FMT_U: imm32 = {inst_i[31:12], 12'b0};
      default: imm32 = '0;
    endcase
  end

  // Every 32-bit immediate has its sign in bit 31, so widening to XLEN
  // is a plain replication of that bit (a no-op when XLEN is 32).
  always_comb begin
    imm_o       = {XLEN{imm32[31]}};
    imm_o[31:0] = imm32;
  end

endmodule

// File: rtl/imm_gen_stage.sv
// Decode stage: extracts immediates and queues decoded entries in a DEPTH-entry FIFO.
// Latency: 1 cycle from accept to out_valid (entry is read straight from storage).
// Backpressure: in_ready is purely count-based (count < DEPTH); a pop does not free a slot for the same cycle's push.
// Ports: clk/rst (sync, active-high), flush; in_valid/in_ready/in_inst/in_pc;
//        out_valid/out_ready/out_imm/out_fmt/out_illegal/out_inst/out_pc; illegal_cnt.
module imm_gen_stage
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic [15:0]     illegal_cnt
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
  } entry_t;

  // Decode ahead of the FIFO so the stored entry is already complete.
  logic [XLEN-1:0] dec_imm;
  fmt_e            dec_fmt;
  logic            dec_illegal;

  imm_extract #(.XLEN(XLEN)) u_extract (
    .inst_i    (in_inst),
    .imm_o     (dec_imm),
    .fmt_o     (dec_fmt),
    .illegal_o (dec_illegal)
  );

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [15:0]     illegal_cnt_q, illegal_cnt_d;
  logic            push, pop;
  entry_t          wr_entry;
  entry_t          head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // rst gates in_ready combinationally so nothing is accepted on a reset edge.
  assign in_ready  = (count_q < CW'(DEPTH)) & ~rst;
  assign out_valid = (count_q != '0);
  // A push coinciding with flush is dropped.
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready;

  assign wr_entry = '{imm: dec_imm, fmt: dec_fmt, illegal: dec_illegal, inst: in_inst, pc: in_pc};
  assign head     = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    illegal_cnt_d = illegal_cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (push && dec_illegal && (illegal_cnt_q != ILLEGAL_CNT_MAX))
        illegal_cnt_d = illegal_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      illegal_cnt_q <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  // Storage needs no reset: outputs are masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

  // Empty FIFO presents the idle values (zeros, format NONE); a stalled head
  // stays put because rd_ptr_q only moves on a pop.
  always_comb begin
    out_imm     = '0;
    out_fmt     = FMT_NONE;
    out_illegal = 1'b0;
    out_inst    = '0;
    out_pc      = '0;
    if (out_valid) begin
      out_imm     = head.imm;
      out_fmt     = head.fmt;
      out_illegal = head.illegal;
      out_inst    = head.inst;
      out_pc      = head.pc;
    end
  end

  assign illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
module tb_imm_gen_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_inst = '0;
  logic [31:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_imm;
  logic [2:0]  out_fmt;
  logic        out_illegal;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [15:0] illegal_cnt;

  // Second instance exercising XLEN=64.
  logic        w_in_valid = 1'b0;
  logic        w_in_ready;
  logic [31:0] w_in_inst = '0;
  logic [63:0] w_in_pc = '0;
  logic        w_out_valid;
  logic [63:0] w_out_imm;
  logic [2:0]  w_out_fmt;
  logic        w_out_illegal;
  logic [31:0] w_out_inst;
  logic [63:0] w_out_pc;
  logic [15:0] w_illegal_cnt;

  always #5 clk = ~clk;

  imm_gen_stage #(.XLEN(32), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_fmt(out_fmt),
    .out_illegal(out_illegal), .out_inst(out_inst), .out_pc(out_pc), .illegal_cnt(illegal_cnt)
  );

  imm_gen_stage #(.XLEN(64), .DEPTH(4)) dut64 (
    .clk(clk), .rst(rst), .flush(1'b0),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_inst(w_in_inst), .in_pc(w_in_pc),
    .out_valid(w_out_valid), .out_ready(1'b1), .out_imm(w_out_imm), .out_fmt(w_out_fmt),
    .out_illegal(w_out_illegal), .out_inst(w_out_inst), .out_pc(w_out_pc), .illegal_cnt(w_illegal_cnt)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode computed arithmetically: field values are weighted by
  // their bit position and the sign is applied by subtracting 2^width.
  function automatic void ref_decode(input logic [31:0] w, output logic [63:0] imm,
                                     output logic [2:0] fmt, output logic ill);
    longint v;
    v   = 0;
    ill = 1'b0;
    case (w[6:0])
      7'h37, 7'h17: begin
        fmt = 3'd4;
        v = longint'(w[31:12]) * 4096;
        if (w[31]) v = v - 64'sh1_0000_0000;
      end
      7'h6F: begin
        fmt = 3'd5;
        v = longint'(w[31]) * (1 << 20) + longint'(w[19:12]) * 4096
          + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2;
        if (w[31]) v = v - (1 << 21);
      end
      7'h67, 7'h03, 7'h13, 7'h73: begin
        fmt = 3'd1;
        v = longint'(w[31:20]);
        if (w[31]) v = v - 4096;
      end
      7'h23: begin
        fmt = 3'd2;
        v = longint'(w[31:25]) * 32 + longint'(w[11:7]);
        if (w[31]) v = v - 4096;
      end
      7'h63: begin
        fmt = 3'd3;
        v = longint'(w[31]) * 4096 + longint'(w[7]) * 2048
          + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2;
        if (w[31]) v = v - 8192;
      end
      7'h33: fmt = 3'd0;
      default: begin
        fmt = 3'd7;
        ill = 1'b1;
      end
    endcase
    imm = 64'(v);
  endfunction

  // Queue model of the 32-bit instance.
  typedef struct { logic [31:0] inst; logic [31:0] pc; } ent_t;
  ent_t        mq[$];
  logic [15:0] mcnt = '0;

  always @(posedge clk) begin
    bit          m_pop, m_push;
    logic [63:0] d_imm;
    logic [2:0]  d_fmt;
    logic        d_ill;
    ent_t        e;
    m_pop  = (mq.size() != 0) && out_ready;
    m_push = in_valid && (mq.size() < 2) && !rst && !flush;
    if (rst) begin
      mq.delete();
      mcnt = '0;
    end else if (flush) begin
      mq.delete();
    end else begin
      if (m_pop) void'(mq.pop_front());
      if (m_push) begin
        e.inst = in_inst;
        e.pc   = in_pc;
        mq.push_back(e);
        ref_decode(in_inst, d_imm, d_fmt, d_ill);
        if (d_ill && mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
      end
    end
  end

  always @(negedge clk) begin
    logic [63:0] d_imm;
    logic [2:0]  d_fmt;
    logic        d_ill;
    if (chk_en) begin
      check("in_ready", 64'(in_ready), 64'((mq.size() < 2) && !rst));
      check("out_valid", 64'(out_valid), 64'(mq.size() != 0));
      check("illegal_cnt", 64'(illegal_cnt), 64'(mcnt));
      if (mq.size() != 0) begin
        ref_decode(mq[0].inst, d_imm, d_fmt, d_ill);
        check("out_imm", 64'(out_imm), 64'(d_imm[31:0]));
        check("out_fmt", 64'(out_fmt), 64'(d_fmt));
        check("out_illegal", 64'(out_illegal), 64'(d_ill));
        check("out_inst", 64'(out_inst), 64'(mq[0].inst));
        check("out_pc", 64'(out_pc), 64'(mq[0].pc));
      end
    end
  end

  logic [31:0] pc_ctr = 32'h1000;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] inst);
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc_ctr;
    pc_ctr   = pc_ctr + 4;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".out_valid"}, 64'(out_valid), 64'd0);
    check({tag, ".out_imm"}, 64'(out_imm), 64'd0);
    check({tag, ".out_fmt"}, 64'(out_fmt), 64'd7);
    check({tag, ".out_illegal"}, 64'(out_illegal), 64'd0);
    check({tag, ".out_inst"}, 64'(out_inst), 64'd0);
    check({tag, ".out_pc"}, 64'(out_pc), 64'd0);
    check({tag, ".illegal_cnt"}, 64'(illegal_cnt), 64'd0);
  endtask

  initial begin
    // Reset state.
    step();
    step();
    check_idle("reset");
    check("reset.in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    #1;
    check("post_reset.in_ready", 64'(in_ready), 64'd1);
    chk_en = 1'b1;

    // Per-format literals, streaming with out_ready=1.
    out_ready = 1'b1;
    drive(32'hFFF00093);
    w_in_valid = 1'b1;
    w_in_inst  = 32'h800000B7;
    w_in_pc    = 64'h8000_0000_0000_0010;
    step();
    check("lit_I.imm", 64'(out_imm), 64'hFFFFFFFF);
    check("lit_I.fmt", 64'(out_fmt), 64'd1);
    check("x64_U.imm", w_out_imm, 64'hFFFFFFFF80000000);
    check("x64_U.fmt", 64'(w_out_fmt), 64'd4);
    check("x64_U.pc", w_out_pc, 64'h8000_0000_0000_0010);
    w_in_valid = 1'b0;
    drive(32'hFE112E23);
    step();
    check("lit_S.imm", 64'(out_imm), 64'hFFFFFFFC);
    check("lit_S.fmt", 64'(out_fmt), 64'd2);
    drive(32'h00000463);
    step();
    check("lit_B.imm", 64'(out_imm), 64'h8);
    check("lit_B.fmt", 64'(out_fmt), 64'd3);
    drive(32'hFFDFF06F);
    step();
    check("lit_J.imm", 64'(out_imm), 64'hFFFFFFFC);
    check("lit_J.fmt", 64'(out_fmt), 64'd5);
    drive(32'h123450B7);
    step();
    check("lit_U.imm", 64'(out_imm), 64'h12345000);
    check("lit_U.fmt", 64'(out_fmt), 64'd4);
    drive(32'h002081B3);
    step();
    check("lit_R.imm", 64'(out_imm), 64'h0);
    check("lit_R.fmt", 64'(out_fmt), 64'd0);
    in_valid = 1'b0;
    step();

    // Backpressure with DEPTH=2.
    out_ready = 1'b0;
    drive(32'h00000463);
    step();
    check("bp.rdy_after1", 64'(in_ready), 64'd1);
    drive(32'hFFDFF06F);
    step();
    check("bp.rdy_after2", 64'(in_ready), 64'd0);
    drive(32'h123450B7);
    step();
    check("bp.held_rdy", 64'(in_ready), 64'd0);
    check("bp.stall_inst", 64'(out_inst), 64'h00000463);
    check("bp.stall_imm", 64'(out_imm), 64'h8);
    out_ready = 1'b1;
    step();
    check("bp.second", 64'(out_inst), 64'hFFDFF06F);
    step();
    check("bp.third", 64'(out_inst), 64'h123450B7);
    in_valid = 1'b0;
    step();
    check("bp.drained", 64'(out_valid), 64'd0);

    // Illegal count and flush.
    drive(32'h0000007F);
    step();
    check("ill.cnt1", 64'(illegal_cnt), 64'd1);
    check("ill.flag", 64'(out_illegal), 64'd1);
    check("ill.fmt", 64'(out_fmt), 64'd7);
    out_ready = 1'b0;
    drive(32'h00100093);
    step();
    drive(32'h00200093);
    step();
    flush = 1'b1;
    drive(32'h0000007F);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush.out_valid", 64'(out_valid), 64'd0);
    check("flush.in_ready", 64'(in_ready), 64'd1);
    check("flush.ill_cnt", 64'(illegal_cnt), 64'd1);
    // Flush with room available: the presented illegal word must still be dropped.
    drive(32'h00300093);
    step();
    flush = 1'b1;
    drive(32'h0000007F);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush2.out_valid", 64'(out_valid), 64'd0);
    check("flush2.ill_cnt", 64'(illegal_cnt), 64'd1);

    // Saturation of illegal_cnt under a sustained one-per-cycle stream.
    out_ready = 1'b1;
    drive(32'h0000007F);
    for (int i = 0; i < 65540; i++) step();
    check("sat.ill_cnt", 64'(illegal_cnt), 64'hFFFF);

    // Mid-stream reset with a mixed stream.
    for (int i = 0; i < 8; i++) begin
      case (i % 4)
        0: drive(32'hFE112E23);
        1: drive(32'h0000007F);
        2: drive(32'h00000463);
        default: drive(32'h123450B7);
      endcase
      out_ready = (i % 3 != 2);
      step();
    end
    rst = 1'b1;
    step();
    check_idle("midrst");
    rst = 1'b0;
    in_valid = 1'b0;
    step();
    check("midrst.in_ready", 64'(in_ready), 64'd1);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
